// File: rtl/layer_4_window_scheduler_pkg.sv
// Shared constants and state encoding for the layer-4 -> conv-5 window scheduler.
package layer_4_window_scheduler_pkg;

  localparam int IMG_W = 10;
  localparam int IMG_H = 10;
  localparam int K     = 3;
  localparam int CNT_W = 10;
  localparam int RC_W  = 4;

  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(IMG_W * IMG_H);
  // Pixel count needed before window (0,0) can issue: its bottom-right pixel plus one.
  localparam logic [CNT_W-1:0] NEED_INIT = CNT_W'((K - 1) * IMG_W + (K - 1) + 1);
  localparam logic [CNT_W-1:0] ROW_WRAP_STEP = CNT_W'(K);
  localparam logic [RC_W-1:0]  LAST_ROW  = RC_W'(IMG_H - K);
  localparam logic [RC_W-1:0]  LAST_COL  = RC_W'(IMG_W - K);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer_4_window_scheduler_if.sv
// Window descriptor handshake between the scheduler (master) and conv-5 engine (slave).
interface layer_4_window_scheduler_if;
  import layer_4_window_scheduler_pkg::*;

  logic             win_valid;
  logic             eng_ready;
  logic [RC_W-1:0]  win_row;
  logic [RC_W-1:0]  win_col;
  logic [CNT_W-1:0] win_base;

  modport master (
    output win_valid, win_row, win_col, win_base,
    input  eng_ready
  );

  modport slave (
    input  win_valid, win_row, win_col, win_base,
    output eng_ready
  );

endinterface

// File: rtl/layer_4_window_scheduler.sv
// Issues 3x3 conv windows over the layer-4 map as soon as the buffer holds their pixels.
//
// state | meaning
// IDLE  | waiting for conv_start; counters held at zero
// RUN   | counting incoming pixels, issuing windows in raster order
// DONE  | one cycle after the last window is accepted; pulses layer_done
module layer_4_window_scheduler
  import layer_4_window_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      conv_start,
  input  logic                      pix_valid,
  layer_4_window_scheduler_if.master win,
  output logic                      busy,
  output logic                      layer_done,
  output logic                      pix_overrun
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] need;
  logic [CNT_W-1:0] base;
  logic [RC_W-1:0]  row;
  logic [RC_W-1:0]  col;
  logic             overrun;
  logic             win_ok;
  logic             accept;
  logic             last_win;
  logic             cnt_full;

  // need and base are running registers so the window ready test needs no multiplier.
  assign cnt_full = (pix_cnt == PIX_TOTAL);
  assign win_ok   = (state == ST_RUN) && (pix_cnt >= need);
  assign accept   = win_ok && win.eng_ready;
  assign last_win = (row == LAST_ROW) && (col == LAST_COL);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; conv_start only counts in IDLE so a pass cannot be restarted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (conv_start) state_nxt = ST_RUN;
      ST_RUN:  if (accept && last_win) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode from registers only; descriptors read as zero outside RUN.
  always_comb begin
    busy          = 1'b0;
    layer_done    = 1'b0;
    win.win_valid = 1'b0;
    win.win_row   = '0;
    win.win_col   = '0;
    win.win_base  = '0;
    pix_overrun   = overrun;
    unique case (state)
      ST_RUN: begin
        busy          = 1'b1;
        win.win_valid = win_ok;
        win.win_row   = row;
        win.win_col   = col;
        win.win_base  = base;
      end
      ST_DONE: layer_done = 1'b1;
      default: ;
    endcase
  end

  // Pixel counter, window position tracking and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      need    <= NEED_INIT;
      base    <= '0;
      row     <= '0;
      col     <= '0;
      overrun <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          pix_cnt <= '0;
          need    <= NEED_INIT;
          base    <= '0;
          row     <= '0;
          col     <= '0;
          if (conv_start) overrun <= 1'b0;
        end
        ST_RUN: begin
          if (pix_valid) begin
            if (cnt_full) overrun <= 1'b1;
            else          pix_cnt <= pix_cnt + CNT_W'(1);
          end
          // The final window stays on the outputs; the pass leaves RUN instead.
          if (accept && !last_win) begin
            if (col == LAST_COL) begin
              col  <= '0;
              row  <= row + RC_W'(1);
              base <= base + ROW_WRAP_STEP;
              need <= need + ROW_WRAP_STEP;
            end else begin
              col  <= col + RC_W'(1);
              base <= base + CNT_W'(1);
              need <= need + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_4_window_scheduler.sv
// Directed bench for the layer-4 window scheduler with a window scoreboard.
module tb_layer_4_window_scheduler;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    int r;
    int c;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic conv_start = 1'b0;
  logic pix_valid = 1'b0;
  logic eng_ready = 1'b0;
  logic busy, layer_done, pix_overrun;

  layer_4_window_scheduler_if wif();
  assign wif.eng_ready = eng_ready;

  layer_4_window_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .conv_start  (conv_start),
    .pix_valid   (pix_valid),
    .win         (wif),
    .busy        (busy),
    .layer_done  (layer_done),
    .pix_overrun (pix_overrun)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  win_t q[$];
  int   mst = M_IDLE;
  int   mcnt = 0;
  logic movr = 1'b0;
  int   acc_cnt, done_cnt, run_len, max_run, first_at;
  bit   first_seen;
  logic obs_valid, obs_ovr;
  int   obs_row, obs_col, obs_base;

  function automatic int need_of(win_t w);
    return (w.r + 2) * 10 + (w.c + 2) + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_run_stats();
    acc_cnt = 0; done_cnt = 0; run_len = 0; max_run = 0;
    first_seen = 0; first_at = -1;
  endtask

  // One clock: drive inputs, check at the falling edge, then advance the model.
  task automatic step(input logic pv, input logic er, input logic cs);
    logic ev;
    conv_start = cs; pix_valid = pv; eng_ready = er;
    @(negedge clk);
    ev = (mst == M_RUN) && (q.size() > 0) && (mcnt >= need_of(q[0]));
    chk("win_valid", wif.win_valid, ev);
    chk("busy", busy, mst == M_RUN);
    chk("layer_done", layer_done, mst == M_DONE);
    chk("pix_overrun", pix_overrun, movr);
    if (ev) begin
      chk("win_row", wif.win_row, q[0].r);
      chk("win_col", wif.win_col, q[0].c);
      chk("win_base", wif.win_base, q[0].r * 10 + q[0].c);
    end else if (mst == M_IDLE) begin
      chk("idle_row", wif.win_row, 0);
      chk("idle_col", wif.win_col, 0);
      chk("idle_base", wif.win_base, 0);
    end
    obs_valid = wif.win_valid; obs_ovr = pix_overrun;
    obs_row = int'(wif.win_row); obs_col = int'(wif.win_col); obs_base = int'(wif.win_base);
    if (wif.win_valid === 1'b1 && !first_seen) begin first_seen = 1; first_at = mcnt; end
    if (wif.win_valid === 1'b1) begin run_len++; if (run_len > max_run) max_run = run_len; end
    else run_len = 0;
    if (wif.win_valid === 1'b1 && er) acc_cnt++;
    if (layer_done === 1'b1) done_cnt++;
    @(posedge clk); #1;
    case (mst)
      M_IDLE: begin
        mcnt = 0;
        if (cs) begin
          mst = M_RUN; movr = 1'b0; q.delete();
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) q.push_back('{r: r, c: c});
        end
      end
      M_RUN: begin
        if (pv) begin
          if (mcnt == 100) movr = 1'b1;
          else mcnt++;
        end
        if (ev && er) begin
          void'(q.pop_front());
          if (q.size() == 0) mst = M_DONE;
        end
      end
      default: mst = M_IDLE;
    endcase
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (mst == M_IDLE && done_cnt != 0) break;
      step(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic run_stream(input string tag);
    clear_run_stats();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
    chk({tag, "_first_valid_pixel"}, first_at, 23);
    step(1'b0, 1'b1, 1'b0);
    chk({tag, "_last_valid"}, obs_valid, 1);
    chk({tag, "_last_row"}, obs_row, 7);
    chk({tag, "_last_col"}, obs_col, 7);
    chk({tag, "_last_base"}, obs_base, 77);
    for (int i = 0; i < 4 && done_cnt == 0; i++) step(1'b0, 1'b1, 1'b0);
    chk({tag, "_accepts"}, acc_cnt, 64);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win_valid", wif.win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", layer_done, 0);
    chk("rst_overrun", pix_overrun, 0);
    chk("rst_base", wif.win_base, 0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);

    // Streaming pass, then a back-to-back pass started in the cycle after layer_done.
    run_stream("stream1");
    run_stream("stream2");

    // Backpressure on window (2,3).
    clear_run_stats();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (q[0].r == 2 && q[0].c == 3) break;
      step(1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("bp_hold_valid", obs_valid, 1);
      chk("bp_hold_row", obs_row, 2);
      chk("bp_hold_col", obs_col, 3);
      chk("bp_hold_base", obs_base, 23);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("bp_next_valid", obs_valid, 1);
    chk("bp_next_row", obs_row, 2);
    chk("bp_next_col", obs_col, 4);
    chk("bp_next_base", obs_base, 24);
    for (int i = 0; i < 100 && mcnt < 100; i++) step(1'b1, 1'b1, 1'b0);
    drain(40);
    chk("bp_done_pulses", done_cnt, 1);

    // Starved input: one pixel every fourth cycle.
    clear_run_stats();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0);
    end
    drain(10);
    chk("starve_accepts", acc_cnt, 64);
    chk("starve_max_run", max_run, 1);
    chk("starve_done_pulses", done_cnt, 1);

    // Overrun, conv_start ignored mid-pass, overrun cleared by the next conv_start.
    clear_run_stats();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 99; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("ovr_set", obs_ovr, 1);
    chk("ovr_restart_ignored_row", obs_row, 7);
    chk("ovr_restart_ignored_col", obs_col, 6);
    drain(10);
    step(1'b0, 1'b1, 1'b0);
    chk("ovr_sticky_idle", obs_ovr, 1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("ovr_cleared", obs_ovr, 0);

    // Asynchronous reset mid-pass with a window pending.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
    chk("pre_reset_valid", obs_valid, 1);
    pix_valid = 1'b0; eng_ready = 1'b0; conv_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", wif.win_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_row", wif.win_row, 0);
    chk("async_rst_col", wif.win_col, 0);
    chk("async_rst_base", wif.win_base, 0);
    chk("async_rst_done", layer_done, 0);
    mst = M_IDLE; mcnt = 0; movr = 1'b0; q.delete();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("post_reset_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
